// File: rtl/piano_game_seq.sv
// piano_game_seq: note-sequence game controller with score, lives and optional per-note timeout
module piano_game_seq #(
  parameter int NOTE_W = 3,
  parameter int SEQ_LEN = 28,
  parameter int MAX_MISS = 3,
  parameter int TIMEOUT = 50_000_000,
  parameter int IDX_W = $clog2(SEQ_LEN + 1),
  parameter int LIV_W = $clog2(MAX_MISS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NOTE_W-1:0] note_sw,
  output logic [IDX_W-1:0]  rom_addr,
  input  logic [NOTE_W-1:0] rom_data,
  output logic              busy,
  output logic              win,
  output logic              lose,
  output logic [IDX_W-1:0]  score,
  output logic [LIV_W-1:0]  lives,
  output logic [NOTE_W-1:0] last_note,
  output logic              hit,
  output logic              miss
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(SEQ_LEN - 1);
  localparam logic [LIV_W-1:0] L_ONE = LIV_W'(1);
  typedef enum logic [2:0] {IDLE, WAIT_NOTE, RELEASE, WIN, LOSE} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] idx, idx_n, score_n;
  logic [LIV_W-1:0] lives_n;
  logic [NOTE_W-1:0] last_n;
  logic [TW-1:0] timer, timer_n;
  logic retry, retry_n, hit_n, miss_n;
  assign rom_addr = idx;
  assign busy = state == WAIT_NOTE || state == RELEASE;
  assign win = state == WIN;
  assign lose = state == LOSE;
  // next-state and next-value logic for the game round
  always_comb begin
    state_n = state;
    idx_n = idx;
    score_n = score;
    lives_n = lives;
    last_n = last_note;
    timer_n = timer;
    retry_n = retry;
    hit_n = 1'b0;
    miss_n = 1'b0;
    case (state)
      WAIT_NOTE:
        if (note_sw != '0) begin
          timer_n = '0;
          if (note_sw == rom_data) begin
            hit_n = 1'b1;
            score_n = score + 1'b1;
            last_n = note_sw;
            retry_n = 1'b0;
            state_n = RELEASE;
          end else begin
            miss_n = 1'b1;
            lives_n = lives - 1'b1;
            retry_n = 1'b1;
            state_n = lives == L_ONE ? LOSE : RELEASE;
          end
        end else if (TIMEOUT != 0 && timer == T_LAST) begin
          miss_n = 1'b1;
          lives_n = lives - 1'b1;
          timer_n = '0;
          state_n = lives == L_ONE ? LOSE : WAIT_NOTE;
        end else if (TIMEOUT != 0) begin
          timer_n = timer + 1'b1;
        end
      RELEASE: begin
        timer_n = '0;
        if (note_sw == '0) begin
          state_n = !retry && idx == I_LAST ? WIN : WAIT_NOTE;
          idx_n = retry || idx == I_LAST ? idx : idx + 1'b1;
        end
      end
      default:
        if (start) begin
          state_n = WAIT_NOTE;
          idx_n = '0;
          score_n = '0;
          lives_n = LIV_W'(MAX_MISS);
          timer_n = '0;
          last_n = '0;
          retry_n = 1'b0;
        end
    endcase
  end
  // register state, counters and the hit/miss pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      score <= '0;
      lives <= '0;
      last_note <= '0;
      timer <= '0;
      retry <= 1'b0;
      hit <= 1'b0;
      miss <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      score <= score_n;
      lives <= lives_n;
      last_note <= last_n;
      timer <= timer_n;
      retry <= retry_n;
      hit <= hit_n;
      miss <= miss_n;
    end
  end
endmodule

// File: tb/tb_piano_game_seq.sv
// tb_piano_game_seq: table, directed and random checks of two game instances against a reference model
module tb_piano_game_seq;
  logic clk, reset, start;
  logic [2:0] note_sw;
  logic [2:0] ra [2];
  logic [2:0] rd [2];
  logic busy [2];
  logic win [2];
  logic lose [2];
  logic [2:0] score [2];
  logic [1:0] lives [2];
  logic [2:0] last [2];
  logic hit [2];
  logic miss [2];
  int errors = 0, checks = 0;
  int rom [4] = '{1, 2, 4, 1};
  int tmo [2] = '{0, 10};
  int ph [2], mi [2], ms [2], ml [2], mn [2], mt [2], mr [2], mh [2], mm [2];
  typedef struct packed {
    logic s;
    logic [2:0] n;
    logic h;
    logic m;
    logic [2:0] sc;
    logic [1:0] lv;
    logic b;
    logic w;
  } vec_t;
  vec_t tbl [$];

  function automatic logic [2:0] rom_f(input logic [2:0] a);
    return a == 3'd0 ? 3'd1 : a == 3'd1 ? 3'd2 : a == 3'd2 ? 3'd4 : 3'd1;
  endfunction
  assign rd[0] = rom_f(ra[0]);
  assign rd[1] = rom_f(ra[1]);

  piano_game_seq #(.NOTE_W(3), .SEQ_LEN(4), .MAX_MISS(3), .TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .note_sw(note_sw), .rom_addr(ra[0]), .rom_data(rd[0]),
    .busy(busy[0]), .win(win[0]), .lose(lose[0]), .score(score[0]), .lives(lives[0]),
    .last_note(last[0]), .hit(hit[0]), .miss(miss[0]));
  piano_game_seq #(.NOTE_W(3), .SEQ_LEN(4), .MAX_MISS(3), .TIMEOUT(10)) dut1 (
    .clk(clk), .reset(reset), .start(start), .note_sw(note_sw), .rom_addr(ra[1]), .rom_data(rd[1]),
    .busy(busy[1]), .win(win[1]), .lose(lose[1]), .score(score[1]), .lives(lives[1]),
    .last_note(last[1]), .hit(hit[1]), .miss(miss[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // phases: 0 idle, 1 waiting for a note, 2 waiting for release, 3 won, 4 lost
  task automatic step(input int k, input bit r, input bit s, input int n);
    mh[k] = 0;
    mm[k] = 0;
    if (r) begin
      ph[k] = 0; mi[k] = 0; ms[k] = 0; ml[k] = 0; mn[k] = 0; mt[k] = 0; mr[k] = 0;
    end else if (ph[k] == 0 || ph[k] >= 3) begin
      if (s) begin
        ph[k] = 1; mi[k] = 0; ms[k] = 0; ml[k] = 3; mn[k] = 0; mt[k] = 0; mr[k] = 0;
      end
    end else if (ph[k] == 1) begin
      if (n != 0) begin
        mt[k] = 0;
        if (n == rom[mi[k]]) begin
          mh[k] = 1; ms[k]++; mn[k] = n; mr[k] = 0; ph[k] = 2;
        end else begin
          mm[k] = 1; ml[k]--; mr[k] = 1; ph[k] = ml[k] == 0 ? 4 : 2;
        end
      end else if (tmo[k] != 0 && mt[k] == tmo[k] - 1) begin
        mm[k] = 1; ml[k]--; mt[k] = 0;
        if (ml[k] == 0) ph[k] = 4;
      end else mt[k]++;
    end else if (n == 0) begin
      if (mr[k] == 0 && mi[k] == 3) ph[k] = 3;
      else begin
        if (mr[k] == 0) mi[k]++;
        ph[k] = 1;
      end
    end
  endtask

  function automatic logic [15:0] act(input int k);
    return {busy[k], win[k], lose[k], score[k], lives[k], last[k], hit[k], miss[k], ra[k]};
  endfunction

  function automatic logic [15:0] expv(input int k);
    return {ph[k] == 1 || ph[k] == 2, ph[k] == 3, ph[k] == 4, 3'(ms[k]), 2'(ml[k]), 3'(mn[k]),
            1'(mh[k]), 1'(mm[k]), 3'(mi[k])};
  endfunction

  task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic tick(input bit r, input bit s, input logic [2:0] n);
    reset = r;
    start = s;
    note_sw = n;
    @(posedge clk);
    for (int k = 0; k < 2; k++) step(k, r, s, int'(n));
    #1;
    chk("model0", act(0), expv(0));
    chk("model1", act(1), expv(1));
  endtask

  function automatic vec_t v(input bit s, input int n, input bit h, input bit m, input int sc,
                             input int lv, input bit b, input bit w);
    return '{s, 3'(n), h, m, 3'(sc), 2'(lv), b, w};
  endfunction

  initial begin
    reset = 1'b1;
    start = 1'b0;
    note_sw = '0;
    tbl.push_back(v(1, 0, 0, 0, 0, 3, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, 1, 3, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 3, 1, 0));
    tbl.push_back(v(0, 2, 1, 0, 2, 3, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 2, 3, 1, 0));
    tbl.push_back(v(0, 4, 1, 0, 3, 3, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 3, 3, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, 4, 3, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 4, 3, 0, 1));
    tbl.push_back(v(0, 2, 0, 0, 4, 3, 0, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 3, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, 1, 3, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 3, 1, 0));
    tbl.push_back(v(0, 4, 0, 1, 1, 2, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 2, 1, 0));
    tbl.push_back(v(0, 2, 1, 0, 2, 2, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 2, 2, 1, 0));
    tick(1, 0, 0);
    tick(1, 1, 1);
    chk("reset0", act(0), 16'h0);
    chk("reset1", act(1), 16'h0);
    foreach (tbl[i]) begin
      tick(0, tbl[i].s, tbl[i].n);
      chk($sformatf("tbl%0d", i), 16'({hit[0], miss[0], score[0], lives[0], busy[0], win[0]}),
          16'({tbl[i].h, tbl[i].m, tbl[i].sc, tbl[i].lv, tbl[i].b, tbl[i].w}));
    end
    chk("miss_idx", 16'(ra[0]), 16'd2);
    tick(1, 0, 0);
    tick(0, 1, 0);
    tick(0, 0, 2);
    tick(0, 0, 0);
    tick(0, 0, 2);
    tick(0, 0, 0);
    tick(0, 0, 4);
    chk("lose_third", 16'({lose[0], lives[0], miss[0], busy[0]}), 16'b1_00_1_0);
    tick(0, 0, 1);
    tick(0, 0, 0);
    chk("lose_frozen", 16'({lose[0], hit[0], miss[0], lives[0]}), 16'b1_0_0_00);
    tick(0, 1, 0);
    chk("lose_restart", 16'({busy[0], lose[0], score[0], lives[0]}), 16'b1_0_000_11);
    tick(1, 0, 0);
    tick(0, 1, 0);
    for (int c = 1; c <= 30; c++) begin
      tick(0, 0, 0);
      chk($sformatf("tmo_c%0d", c), 16'({miss[1], lose[1]}), 16'({c % 10 == 0, c == 30}));
    end
    chk("tmo_lives", 16'(lives[1]), 16'd0);
    chk("notmo_busy", 16'({busy[0], lives[0]}), 16'b1_11);
    tick(0, 1, 0);
    for (int c = 0; c < 9; c++) tick(0, 0, 0);
    tick(0, 0, 1);
    chk("expiry_hit", 16'({hit[1], miss[1], lives[1], score[1]}), 16'b1_0_11_001);
    tick(1, 0, 0);
    tick(0, 1, 0);
    tick(0, 0, 3);
    chk("chord", 16'({miss[0], hit[0], lives[0]}), 16'b1_0_10);
    tick(0, 0, 3);
    tick(0, 0, 1);
    chk("hold_noeval", 16'({hit[0], miss[0], busy[0], score[0]}), 16'b0_0_1_000);
    tick(0, 0, 0);
    tick(0, 0, 1);
    chk("after_release", 16'({hit[0], score[0], ra[0]}), 16'b1_001_000);
    tick(1, 0, 0);
    tick(0, 1, 0);
    tick(0, 0, 1);
    tick(0, 0, 0);
    tick(0, 0, 2);
    tick(0, 1, 2);
    chk("start_rel", 16'({score[0], ra[0], lives[0]}), 16'b010_001_11);
    tick(0, 0, 0);
    tick(0, 1, 0);
    chk("start_wait", 16'({score[0], ra[0], lives[0], busy[0]}), 16'b010_010_11_1);
    tick(1, 0, 0);
    chk("midreset0", act(0), 16'h0);
    chk("midreset1", act(1), 16'h0);
    for (int i = 0; i < 600; i++) begin
      int x = $urandom_range(0, 9);
      int run = $urandom_range(1, 12);
      logic [2:0] n = x < 4 ? 3'd0 : x < 7 ? 3'(rom[mi[0]]) : 3'($urandom_range(0, 7));
      for (int j = 0; j < run; j++) tick($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, n);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
